piso_serializer: RTL and testbench

- Parametrised parallel-in/serial-out serializer; successor to the fixed 20-bit capture/shift register.
- Adds generic width, selectable bit order, a valid/ready load handshake and a one-word holding buffer, so back-to-back words stream with no idle cycle.
- Adds per-bit s_valid/s_last framing.
- Sits between a parallel word producer and a serial link or test-data shifter.

---
 rtl/piso_serializer.sv | 124 ++++++++++++
 tb/tb_piso_serializer.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/piso_serializer.sv
// Parallel-in/serial-out serializer with a one-word holding buffer and per-bit framing.
// Optional even-parity trailer bit: define PISO_SERIALIZER_PARITY_EN.
module piso_serializer #(
  parameter int unsigned WIDTH     = 20,
  parameter bit          LSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             p_valid,
  output logic             p_ready,
  input  logic [WIDTH-1:0] p_data,
  input  logic             shift_en,
  output logic             s_out,
  output logic             s_valid,
  output logic             s_last,
  output logic             busy
);

`ifdef PISO_SERIALIZER_PARITY_EN
  localparam int unsigned FRAME = WIDTH + 1;
`else
  localparam int unsigned FRAME = WIDTH;
`endif
  localparam int unsigned   CW      = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LastCnt = CW'(FRAME - 1);

  typedef enum logic {StIdle, StShift} state_e;

  state_e           r_state;
  logic [WIDTH-1:0] r_sreg;
  logic [WIDTH-1:0] r_hold;
  logic             r_hold_full;
  logic [CW-1:0]    r_cnt;

  logic             w_accept;
  logic             w_last;
  logic             w_finish;
  logic             w_load_data;
  logic             w_load_hold;
  logic             w_data_bit;
  logic             w_bit;
  logic [WIDTH-1:0] w_shifted;

  assign w_accept    = p_valid & ~r_hold_full;
  assign w_last      = (r_state == StShift) && (r_cnt == LastCnt);
  assign w_finish    = w_last & shift_en;
  // A new frame starts from p_data when idle, or bypasses the empty hold on the final bit.
  assign w_load_data = w_accept & ((r_state == StIdle) | (w_finish & ~r_hold_full));
  assign w_load_hold = w_finish & r_hold_full;

  assign w_data_bit = LSB_FIRST ? r_sreg[0] : r_sreg[WIDTH-1];
  assign w_shifted  = LSB_FIRST ? {1'b0, r_sreg[WIDTH-1:1]} : {r_sreg[WIDTH-2:0], 1'b0};

`ifdef PISO_SERIALIZER_PARITY_EN
  logic r_par;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_par <= 1'b0;
    end else if (w_load_data) begin
      r_par <= ^p_data;
    end else if (w_load_hold) begin
      r_par <= ^r_hold;
    end
  end

  assign w_bit = (r_cnt == CW'(WIDTH)) ? r_par : w_data_bit;
`else
  assign w_bit = w_data_bit;
`endif

  assign s_valid = (r_state == StShift);
  assign s_out   = s_valid & w_bit;
  assign s_last  = w_last;
  assign p_ready = ~r_hold_full;
  assign busy    = s_valid | r_hold_full;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= StIdle;
      r_sreg      <= '0;
      r_hold      <= '0;
      r_hold_full <= 1'b0;
      r_cnt       <= '0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (w_load_data) begin
            r_sreg  <= p_data;
            r_cnt   <= '0;
            r_state <= StShift;
          end
        end
        StShift: begin
          if (w_finish) begin
            if (w_load_hold) begin
              r_sreg      <= r_hold;
              r_hold_full <= 1'b0;
              r_cnt       <= '0;
            end else if (w_load_data) begin
              r_sreg <= p_data;
              r_cnt  <= '0;
            end else begin
              r_sreg  <= '0;
              r_cnt   <= '0;
              r_state <= StIdle;
            end
          end else begin
            if (shift_en) begin
              r_sreg <= w_shifted;
              r_cnt  <= r_cnt + CW'(1);
            end
            if (w_accept) begin
              r_hold      <= p_data;
              r_hold_full <= 1'b1;
            end
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_piso_serializer.sv
// Bench for piso_serializer: one LSB-first and one MSB-first instance driven identically,
// each compared every cycle against a queue-of-words reference model.
module tb_piso_serializer;

  localparam int W = 20;
`ifdef PISO_SERIALIZER_PARITY_EN
  localparam int FRAME = W + 1;
`else
  localparam int FRAME = W;
`endif

  logic         clk;
  logic         rst;
  logic         p_valid;
  logic [W-1:0] p_data;
  logic         shift_en;
  logic         a_ready, a_out, a_valid, a_last, a_busy;
  logic         b_ready, b_out, b_valid, b_last, b_busy;

  int checks   = 0;
  int failures = 0;
  string phase = "reset";

  // Model: q holds every accepted word not yet fully sent; q[0] is on the wire at bit pos.
  logic [W-1:0] q[$];
  int           pos = 0;

  piso_serializer #(.WIDTH(W), .LSB_FIRST(1'b1)) u_lsb (
    .clk(clk), .rst(rst), .p_valid(p_valid), .p_ready(a_ready), .p_data(p_data),
    .shift_en(shift_en), .s_out(a_out), .s_valid(a_valid), .s_last(a_last), .busy(a_busy)
  );

  piso_serializer #(.WIDTH(W), .LSB_FIRST(1'b0)) u_msb (
    .clk(clk), .rst(rst), .p_valid(p_valid), .p_ready(b_ready), .p_data(p_data),
    .shift_en(shift_en), .s_out(b_out), .s_valid(b_valid), .s_last(b_last), .busy(b_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic frame_bit(input logic [W-1:0] w, input int i, input bit lsb);
    if (i >= W) return ^w;
    return lsb ? w[i] : w[W-1-i];
  endfunction

  task automatic cmp(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s/%s observed=%b expected=%b at %0t", phase, tag, obs, exp, $time);
    end
  endtask

  task automatic check();
    logic ev, er, el, eoa, eob;
    ev  = (q.size() > 0);
    er  = (q.size() < 2);
    el  = ev && (pos == FRAME - 1);
    eoa = ev ? frame_bit(q[0], pos, 1'b1) : 1'b0;
    eob = ev ? frame_bit(q[0], pos, 1'b0) : 1'b0;
    cmp("lsb_valid", a_valid, ev);
    cmp("lsb_out",   a_out,   eoa);
    cmp("lsb_last",  a_last,  el);
    cmp("lsb_ready", a_ready, er);
    cmp("lsb_busy",  a_busy,  ev);
    cmp("msb_valid", b_valid, ev);
    cmp("msb_out",   b_out,   eob);
    cmp("msb_last",  b_last,  el);
    cmp("msb_ready", b_ready, er);
    cmp("msb_busy",  b_busy,  ev);
  endtask

  task automatic model_edge();
    bit acc;
    if (rst) begin
      q.delete();
      pos = 0;
      return;
    end
    acc = p_valid && (q.size() < 2);
    if (q.size() > 0 && shift_en) begin
      pos++;
      if (pos == FRAME) begin
        void'(q.pop_front());
        pos = 0;
      end
    end
    if (acc) q.push_back(p_data);
  endtask

  // Called in the low clock phase: drive, check current outputs, advance one edge.
  task automatic cyc(input logic v, input logic [W-1:0] d, input logic se);
    p_valid  = v;
    p_data   = d;
    shift_en = se;
    check();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, '0, 1'b1);
  endtask

  initial begin
    rst      = 1'b1;
    p_valid  = 1'b0;
    p_data   = '0;
    shift_en = 1'b0;
    @(negedge clk);
    cyc(1'b0, '0, 1'b0);
    cyc(1'b1, 20'h12345, 1'b1);  // ignored while in reset
    rst = 1'b0;
    idle(1);

    phase = "single";
    cyc(1'b1, 20'h06850, 1'b1);
    idle(FRAME + 2);
    cyc(1'b1, 20'h06851, 1'b1);
    idle(FRAME + 2);

    phase = "b2b";
    cyc(1'b1, 20'hFFFFF, 1'b1);
    cyc(1'b1, 20'h00001, 1'b1);
    for (int i = 0; i < 2 * FRAME + 3; i++) cyc(1'b1, 20'h0BEEF, 1'b1);  // blocked while held
    p_valid = 1'b0;
    idle(2 * FRAME + 3);

    phase = "stall";
    cyc(1'b1, 20'hA5A5A, 1'b1);
    for (int i = 0; i < 3 * FRAME + 4; i++) cyc(1'b0, '0, (i % 3) == 2);
    idle(FRAME + 2);

    phase = "bypass";
    cyc(1'b1, 20'h3C3C3, 1'b1);
    for (int i = 0; i < FRAME - 1; i++) cyc(1'b0, '0, 1'b1);
    cyc(1'b1, 20'h5A5A5, 1'b1);
    idle(FRAME + 2);

    phase = "midrst";
    cyc(1'b1, 20'h13579, 1'b1);
    cyc(1'b1, 20'h2468A, 1'b1);
    for (int i = 0; i < 5; i++) cyc(1'b0, '0, 1'b1);
    rst = 1'b1;
    #1;
    q.delete();
    pos = 0;
    check();
    @(negedge clk);
    cyc(1'b0, '0, 1'b1);
    rst = 1'b0;
    idle(FRAME + 3);

    phase = "random";
    for (int i = 0; i < 600; i++) begin
      cyc(1'($urandom_range(0, 1)), W'($urandom), ($urandom_range(0, 3) != 0));
    end
    idle(2 * FRAME + 4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
